// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and address type for the integer register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int CNT_W_DEF = 2;

   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

   typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: reserved at issue, released at writeback commit.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int CNT_W = CNT_W_DEF,
   localparam int AW   = addr_w(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic              issue_en,
   input  logic [AW-1:0]     issue_addr,
   output logic              issue_ready
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt [NREGS];
   logic             issue_acc;
   logic             release_ok;

   assign issue_ready = (issue_addr == '0) || (cnt[issue_addr] != CNT_MAX);
   assign issue_acc   = issue_en && issue_ready && (issue_addr != '0);
   assign release_ok  = wr_en && (wr_addr != '0) && (cnt[wr_addr] != '0);

   // Counter 0 can never move: both issue and release exclude address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if ((issue_acc && issue_addr == AW'(r)) && !(release_ok && wr_addr == AW'(r)))
               cnt[r] <= cnt[r] + 1'b1;
            else if ((release_ok && wr_addr == AW'(r)) && !(issue_acc && issue_addr == AW'(r)))
               cnt[r] <= cnt[r] - 1'b1;
         end
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int k = 0; k < NRD; k++)
         rd_busy[k] = (cnt[rd_addr[k*AW +: AW]] != '0);
   end

endmodule

// File: rtl/multiport_regfile.sv
// RV32I register file: NRD combinational read ports, one write port, optional bypass, pending-write scoreboard.
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   parameter int CNT_W  = CNT_W_DEF,
   localparam int AW    = addr_w(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_addr,
   output logic                issue_ready
);

   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) mem[r] <= '0;
      end else if (wr_en && wr_addr != '0) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Address 0 is forced to zero on the read side so it never depends on mem[0].
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         if (rd_addr[k*AW +: AW] == '0)
            rd_data[k*XLEN +: XLEN] = '0;
         else if (BYPASS == 1 && wr_en && !rst && wr_addr == rd_addr[k*AW +: AW])
            rd_data[k*XLEN +: XLEN] = wr_data;
         else
            rd_data[k*XLEN +: XLEN] = mem[rd_addr[k*AW +: AW]];
      end
   end

   reg_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .rd_addr     (rd_addr),
      .rd_busy     (rd_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .issue_en    (issue_en),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready)
   );

endmodule
